// File: rtl/mips16_loader_pkg.sv
// Shared widths, command bytes and FSM encoding for the mips16_sc program loader.
package mips16_loader_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BYTES_PER_INSTR = 4;
    localparam int unsigned BYTES_PER_REG   = 2;
    localparam int unsigned IMEM_ADDR_W     = 8;
    localparam int unsigned INSTR_W         = BYTES_PER_INSTR * BYTE_W;
    localparam int unsigned REG_ADDR_W      = 3;
    localparam int unsigned DATA_W          = BYTES_PER_REG * BYTE_W;
    localparam int unsigned CNT_W           = IMEM_ADDR_W + 1;

    localparam logic [BYTE_W-1:0] CMD_LOAD = 8'h4C;
    localparam logic [BYTE_W-1:0] CMD_DUMP = 8'h44;
    localparam logic [BYTE_W-1:0] CMD_HOLD = 8'h48;
    localparam logic [BYTE_W-1:0] CMD_RUN  = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_BYTE,
        ST_LOAD_WRITE,
        ST_DUMP_RD,
        ST_DUMP_HI,
        ST_DUMP_LO
    } loader_state_e;

endpackage

// File: rtl/mips16_prog_loader_word_assembler.sv
// Big-endian byte-to-word shift register; word_done_c flags the byte that completes a word.
module loader_word_assembler
    import mips16_loader_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [BYTE_W-1:0]  data,
    output logic [INSTR_W-1:0] word_c,
    output logic               word_done_c
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_INSTR);

    logic [INSTR_W-1:0] word;
    logic [IDX_W-1:0]   idx;

    // Word as it will look once the current byte is shifted in.
    assign word_c      = {word[INSTR_W-BYTE_W-1:0], data};
    assign word_done_c = shift_en && (idx == IDX_W'(BYTES_PER_INSTR - 1));

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            word <= '0;
            idx  <= '0;
        end else if (shift_en) begin
            word <= word_c;
            idx  <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/mips16_prog_loader.sv
// Command-driven program loader and register dump port for the mips16_sc core.
module mips16_prog_loader
    import mips16_loader_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic [BYTE_W-1:0]      rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [INSTR_W-1:0]     imem_wdata,
    output logic [REG_ADDR_W-1:0]  reg_rd_addr,
    input  logic [DATA_W-1:0]      reg_rd_data,
    output logic                   cpu_hold,
    output logic                   busy,
    output logic                   cmd_error
);

    loader_state_e          state, state_next;
    logic                   rx_ready_next, tx_valid_next, imem_we_next;
    logic                   busy_next, cmd_error_next, hold_next;
    logic [BYTE_W-1:0]      tx_data_next;
    logic [IMEM_ADDR_W-1:0] addr_next;
    logic [INSTR_W-1:0]     wdata_next;
    logic [REG_ADDR_W-1:0]  rd_addr_next;
    logic [CNT_W-1:0]       cnt, cnt_next;
    logic                   saved_hold, saved_next;
    logic [DATA_W-1:0]      dump_word, dump_word_next;
    logic                   asm_clear, asm_shift, asm_done;
    logic [INSTR_W-1:0]     asm_word;
    logic                   accept, tx_fire;

    assign accept  = rx_valid && rx_ready;
    assign tx_fire = tx_valid && tx_ready;

    loader_word_assembler u_asm (
        .clock       (clock),
        .reset       (reset),
        .clear       (asm_clear),
        .shift_en    (asm_shift),
        .data        (rx_data),
        .word_c      (asm_word),
        .word_done_c (asm_done)
    );

    // Next-state and next-output decode; every output is re-registered below.
    always_comb begin
        state_next     = state;
        hold_next      = cpu_hold;
        saved_next     = saved_hold;
        cnt_next       = cnt;
        addr_next      = imem_addr;
        wdata_next     = imem_wdata;
        rd_addr_next   = reg_rd_addr;
        dump_word_next = dump_word;
        tx_data_next   = tx_data;
        cmd_error_next = 1'b0;
        asm_clear      = 1'b0;
        asm_shift      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (rx_data)
                        CMD_LOAD: state_next = ST_LOAD_CNT;
                        CMD_DUMP: begin
                            state_next   = ST_DUMP_RD;
                            saved_next   = cpu_hold;
                            hold_next    = 1'b1;
                            rd_addr_next = '0;
                        end
                        CMD_HOLD: hold_next = 1'b1;
                        CMD_RUN:  hold_next = 1'b0;
                        default:  cmd_error_next = 1'b1;
                    endcase
                end
            end
            ST_LOAD_CNT: begin
                if (accept) begin
                    // A count byte of zero stands for a full 256-word image.
                    cnt_next   = (rx_data == '0) ? CNT_W'(1 << IMEM_ADDR_W) : CNT_W'(rx_data);
                    hold_next  = 1'b1;
                    addr_next  = '0;
                    asm_clear  = 1'b1;
                    state_next = ST_LOAD_BYTE;
                end
            end
            ST_LOAD_BYTE: begin
                if (accept) begin
                    asm_shift = 1'b1;
                    if (asm_done) begin
                        wdata_next = asm_word;
                        state_next = ST_LOAD_WRITE;
                    end
                end
            end
            ST_LOAD_WRITE: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hold_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    addr_next  = imem_addr + IMEM_ADDR_W'(1);
                    state_next = ST_LOAD_BYTE;
                end
            end
            ST_DUMP_RD: begin
                dump_word_next = reg_rd_data;
                tx_data_next   = reg_rd_data[DATA_W-1:DATA_W-BYTE_W];
                state_next     = ST_DUMP_HI;
            end
            ST_DUMP_HI: begin
                if (tx_fire) begin
                    tx_data_next = dump_word[BYTE_W-1:0];
                    state_next   = ST_DUMP_LO;
                end
            end
            ST_DUMP_LO: begin
                if (tx_fire) begin
                    tx_data_next = '0;
                    if (reg_rd_addr == '1) begin
                        hold_next  = saved_hold;
                        state_next = ST_IDLE;
                    end else begin
                        rd_addr_next = reg_rd_addr + REG_ADDR_W'(1);
                        state_next   = ST_DUMP_RD;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        rx_ready_next = (state_next == ST_IDLE) || (state_next == ST_LOAD_CNT)
                     || (state_next == ST_LOAD_BYTE);
        tx_valid_next = (state_next == ST_DUMP_HI) || (state_next == ST_DUMP_LO);
        imem_we_next  = (state_next == ST_LOAD_WRITE);
        busy_next     = (state_next != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            cpu_hold    <= 1'b1;
            saved_hold  <= 1'b1;
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            reg_rd_addr <= '0;
            busy        <= 1'b0;
            cmd_error   <= 1'b0;
            cnt         <= '0;
            dump_word   <= '0;
        end else begin
            state       <= state_next;
            cpu_hold    <= hold_next;
            saved_hold  <= saved_next;
            rx_ready    <= rx_ready_next;
            tx_valid    <= tx_valid_next;
            tx_data     <= tx_data_next;
            imem_we     <= imem_we_next;
            imem_addr   <= addr_next;
            imem_wdata  <= wdata_next;
            reg_rd_addr <= rd_addr_next;
            busy        <= busy_next;
            cmd_error   <= cmd_error_next;
            cnt         <= cnt_next;
            dump_word   <= dump_word_next;
        end
    end

endmodule

// File: tb/tb_mips16_prog_loader.sv
// Randomized self-checking bench for mips16_prog_loader against a transaction-level model.
module tb_mips16_prog_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  reg_rd_addr;
    logic [15:0] reg_rd_data;
    logic        cpu_hold;
    logic        busy;
    logic        cmd_error;

    mips16_prog_loader dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .cmd_error   (cmd_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
        logic        last;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    wr_t         wr_q[$];
    logic [7:0]  tx_q[$];
    logic [15:0] regs [8];
    logic [31:0] load_words [256];
    logic        model_hold = 1'b1;
    int          err_expected = 0;
    int          err_seen = 0;
    int          n_writes = 0;

    assign reg_rd_data = regs[reg_rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Sink back-pressure: tx_ready toggles randomly, changed just after each rising edge.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Per-cycle monitor: writes and tx bytes against the expected queues, plus protocol rules.
    initial begin
        logic       prev_valid = 1'b0;
        logic       prev_ready = 1'b0;
        logic [7:0] prev_data = '0;
        logic       check_release = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_valid    = 1'b0;
                check_release = 1'b0;
            end else begin
                if (check_release) begin
                    check("release_hold", 32'(cpu_hold), 32'(0));
                    check("release_busy", 32'(busy), 32'(0));
                    check_release = 1'b0;
                end
                if (imem_we) begin
                    int  have;
                    wr_t e;
                    have = wr_q.size();
                    check("write_expected", 32'(have > 0), 32'(1));
                    check("hold_in_write", 32'(cpu_hold), 32'(1));
                    check("rx_ready_in_write", 32'(rx_ready), 32'(0));
                    if (have > 0) begin
                        e = wr_q.pop_front();
                        check("wr_addr", 32'(imem_addr), 32'(e.addr));
                        check("wr_data", imem_wdata, e.data);
                        check_release = e.last;
                    end
                    n_writes++;
                end
                if (prev_valid && !prev_ready) begin
                    check("tx_valid_stable", 32'(tx_valid), 32'(1));
                    check("tx_data_stable", 32'(tx_data), 32'(prev_data));
                end
                if (tx_valid) begin
                    check("hold_in_dump", 32'(cpu_hold), 32'(1));
                    check("rx_ready_in_dump", 32'(rx_ready), 32'(0));
                    check("busy_in_dump", 32'(busy), 32'(1));
                    if (tx_ready) begin
                        int have_tx;
                        have_tx = tx_q.size();
                        check("tx_expected", 32'(have_tx > 0), 32'(1));
                        if (have_tx > 0) check("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
                    end
                end
                if (cmd_error) err_seen++;
                prev_valid = tx_valid;
                prev_ready = tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    // Offer one byte from a falling edge; returns on the falling edge after it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        repeat ($urandom_range(0, 1)) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom_range(0, 255));
            @(negedge clock);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 2000) check("rx_accept_timeout", 32'(waited), 32'(0));
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(n < 5000), 32'(1));
        @(negedge clock);
        @(negedge clock);
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_hold"}, 32'(cpu_hold), 32'(model_hold));
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'(1));
        check({tag, "_writes_left"}, 32'(wr_q.size()), 32'(0));
        check({tag, "_tx_left"}, 32'(tx_q.size()), 32'(0));
        check({tag, "_cmd_errors"}, 32'(err_seen), 32'(err_expected));
    endtask

    task automatic do_load(input int n);
        for (int i = 0; i < n; i++)
            wr_q.push_back(wr_t'{addr: 8'(i), data: load_words[i], last: (i == n - 1)});
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                send_byte(load_words[i][31 - 8 * b -: 8]);
        model_hold = 1'b0;
        wait_idle("load");
    endtask

    task automatic do_dump();
        for (int r = 0; r < 8; r++) begin
            tx_q.push_back(regs[r][15:8]);
            tx_q.push_back(regs[r][7:0]);
        end
        send_byte(8'h44);
        wait_idle("dump");
    endtask

    task automatic simple_cmd(input logic [7:0] b);
        send_byte(b);
        if (b == 8'h48) model_hold = 1'b1;
        else if (b == 8'h52) model_hold = 1'b0;
        else err_expected++;
        wait_idle("cmd");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished checks=%0d", checks);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int base;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        for (int r = 0; r < 8; r++) regs[r] = 16'(r);

        // Reset values while reset is held.
        @(negedge clock);
        @(negedge clock);
        check("rst_hold", 32'(cpu_hold), 32'(1));
        check("rst_rx_ready", 32'(rx_ready), 32'(0));
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_imem_we", 32'(imem_we), 32'(0));
        check("rst_imem_addr", 32'(imem_addr), 32'(0));
        check("rst_imem_wdata", imem_wdata, 32'(0));
        check("rst_reg_rd_addr", 32'(reg_rd_addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cmd_error", 32'(cmd_error), 32'(0));
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("idle_hold", 32'(cpu_hold), 32'(1));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_tx_valid", 32'(tx_valid), 32'(0));
        check("idle_writes", 32'(n_writes), 32'(0));

        // Two-word program with literal words.
        load_words[0] = 32'h0022_1820;
        load_words[1] = 32'hAC01_0004;
        do_load(2);
        check("two_word_writes", 32'(n_writes), 32'(2));

        // Dump of 0..7 with cpu released beforehand.
        do_dump();

        // Unknown command, then run and hold.
        simple_cmd(8'h5A);
        check("err_after_5a", 32'(err_seen), 32'(1));
        simple_cmd(8'h52);
        check("hold_after_run", 32'(cpu_hold), 32'(0));
        simple_cmd(8'h48);
        check("hold_after_hold", 32'(cpu_hold), 32'(1));

        // Full 256-word image with count byte 0x00.
        for (int i = 0; i < 256; i++) load_words[i] = $urandom;
        base = n_writes;
        do_load(256);
        check("full_image_writes", 32'(n_writes - base), 32'(256));
        check("full_image_last_addr", 32'(imem_addr), 32'(8'hFF));

        // Reset in the middle of a word: nothing written, fresh dump afterwards.
        base = n_writes;
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_hold = 1'b1;
        @(negedge clock);
        check("abort_no_write", 32'(n_writes - base), 32'(0));
        check("abort_hold", 32'(cpu_hold), 32'(1));
        for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
        do_dump();

        // Random command mix.
        for (int it = 0; it < 16; it++) begin
            int         sel;
            int         n;
            logic [7:0] b;
            sel = $urandom_range(0, 4);
            case (sel)
                0: begin
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) load_words[i] = $urandom;
                    do_load(n);
                end
                1: begin
                    for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
                    do_dump();
                end
                2: simple_cmd(8'h48);
                3: simple_cmd(8'h52);
                default: begin
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'h4C || b == 8'h44 || b == 8'h48 || b == 8'h52);
                    simple_cmd(b);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
